mby_gmm_msh_req_port: RTL and testbench



---
 rtl/mby_gmm_msh_req_port_if.sv | 35 +++
 rtl/mby_gmm_msh_req_port.sv | 120 ++++++++++++
 tb/tb_mby_gmm_msh_req_port.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mby_gmm_msh_req_port_if.sv
// mby_gmm_msh_req_port_if: client request and mesh request/credit signals of the GMM mesh request port
interface mby_gmm_msh_req_port_if #(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 64,
    parameter int CREDITS = 8,
    parameter int CH_W    = $clog2(N_CH),
    parameter int CRD_W   = $clog2(CREDITS + 1)
);
    logic [N_CH-1:0]        ch_req_valid;
    logic [N_CH-1:0]        ch_req_ready;
    logic [N_CH-1:0]        ch_req_wr;
    logic [N_CH*ADDR_W-1:0] ch_req_addr;
    logic [N_CH*DATA_W-1:0] ch_req_data;
    logic                   msh_req_valid;
    logic [CH_W-1:0]        msh_req_ch;
    logic                   msh_req_wr;
    logic [ADDR_W-1:0]      msh_req_addr;
    logic [DATA_W-1:0]      msh_req_data;
    logic                   msh_crd_rtn;
    logic [CRD_W-1:0]       crd_cnt;
    logic                   crd_err;

    modport slave (
        input  ch_req_valid, ch_req_wr, ch_req_addr, ch_req_data, msh_crd_rtn,
        output ch_req_ready, msh_req_valid, msh_req_ch, msh_req_wr, msh_req_addr, msh_req_data,
               crd_cnt, crd_err
    );

    modport master (
        output ch_req_valid, ch_req_wr, ch_req_addr, ch_req_data, msh_crd_rtn,
        input  ch_req_ready, msh_req_valid, msh_req_ch, msh_req_wr, msh_req_addr, msh_req_data,
               crd_cnt, crd_err
    );
endinterface

// File: rtl/mby_gmm_msh_req_port.sv
// mby_gmm_msh_req_port: per-channel request FIFOs, round-robin arbiter and credit-gated mesh request issue
module mby_gmm_msh_req_port #(
    parameter int N_CH       = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8,
    parameter int CH_W       = $clog2(N_CH),
    parameter int CRD_W      = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mby_gmm_msh_req_port_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    logic [ENT_W-1:0]              mem_q [N_CH][FIFO_DEPTH];
    logic [ENT_W-1:0]              mem_d [N_CH][FIFO_DEPTH];
    logic [N_CH-1:0][PTR_W-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [N_CH-1:0][PTR_W:0]      cnt_q, cnt_d;
    logic [N_CH-1:0]               push, pop, nonempty;
    logic [CH_W-1:0]               rr_q, rr_d, gnt, idx;
    logic                          found, issue, sat;
    logic [ENT_W-1:0]              head;
    logic                          vld_q, vld_d, wr_q, wr_d, err_q, err_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic [CRD_W-1:0]              crd_q, crd_d;

    always_comb begin
        nonempty         = '0;
        bus.ch_req_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            nonempty[i]         = |cnt_q[i];
            bus.ch_req_ready[i] = cnt_q[i] != (PTR_W+1)'(FIFO_DEPTH);
        end
    end

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CH_W'((int'(rr_q) + k) % N_CH);
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        issue = found && crd_q != '0;
        head  = mem_q[gnt][rp_q[gnt]];
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        push  = '0;
        pop   = '0;
        for (int i = 0; i < N_CH; i++) begin
            push[i] = bus.ch_req_valid[i] && bus.ch_req_ready[i];
            pop[i]  = issue && gnt == CH_W'(i);
            if (push[i]) begin
                mem_d[i][wp_q[i]] = {bus.ch_req_wr[i], bus.ch_req_addr[i*ADDR_W +: ADDR_W],
                                     bus.ch_req_data[i*DATA_W +: DATA_W]};
                wp_d[i]           = wp_q[i] + PTR_W'(1);
            end
            rp_d[i]  = pop[i] ? rp_q[i] + PTR_W'(1) : rp_q[i];
            cnt_d[i] = cnt_q[i] + (PTR_W+1)'(push[i]) - (PTR_W+1)'(pop[i]);
        end
        rr_d   = issue ? (gnt == CH_W'(N_CH - 1) ? '0 : gnt + CH_W'(1)) : rr_q;
        vld_d  = issue;
        ch_d   = issue ? gnt : ch_q;
        wr_d   = issue ? head[ENT_W-1] : wr_q;
        addr_d = issue ? head[DATA_W +: ADDR_W] : addr_q;
        data_d = issue ? (head[ENT_W-1] ? head[DATA_W-1:0] : '0) : data_q;
        // A return at full credit with nothing issuing would overflow: hold the count and flag it
        sat    = bus.msh_crd_rtn && !issue && crd_q == CRD_W'(CREDITS);
        crd_d  = sat ? crd_q : crd_q - CRD_W'(issue) + CRD_W'(bus.msh_crd_rtn);
        err_d  = err_q | sat;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            rr_q   <= '0;
            vld_q  <= 1'b0;
            ch_q   <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            crd_q  <= CRD_W'(CREDITS);
            err_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            ch_q   <= ch_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            crd_q  <= crd_d;
            err_q  <= err_d;
        end
    end

    assign bus.msh_req_valid = vld_q;
    assign bus.msh_req_ch    = ch_q;
    assign bus.msh_req_wr    = wr_q;
    assign bus.msh_req_addr  = addr_q;
    assign bus.msh_req_data  = data_q;
    assign bus.crd_cnt       = crd_q;
    assign bus.crd_err       = err_q;
endmodule

// File: tb/tb_mby_gmm_msh_req_port.sv
// tb_mby_gmm_msh_req_port: scoreboard bench for the GMM mesh request port
module tb_mby_gmm_msh_req_port;
    localparam int N_CH = 4, ADDR_W = 20, DATA_W = 64, FIFO_DEPTH = 4, CREDITS = 8;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0, n_chk = 0, n_fail = 0, n_iss = 0, last_iss = 0, acc_cyc = 0;
    logic held_done = 1'b0;
    logic [ENT_W-1:0] sbq [N_CH][$];
    int ord_q[$];
    logic pay_wr [N_CH];
    logic [ADDR_W-1:0] pay_addr [N_CH];
    logic [DATA_W-1:0] pay_data [N_CH];

    mby_gmm_msh_req_port_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CREDITS(CREDITS)) bus ();

    mby_gmm_msh_req_port #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                           .FIFO_DEPTH(FIFO_DEPTH), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.msh_req_valid) begin
            n_iss++;
            last_iss = cyc;
            if (sbq[bus.msh_req_ch].size() == 0) chk("spurious_issue", 1, 0);
            else chk("payload", {bus.msh_req_wr, bus.msh_req_addr, bus.msh_req_data},
                     sbq[bus.msh_req_ch].pop_front());
            if (ord_q.size() != 0) chk("grant_order", bus.msh_req_ch, ord_q.pop_front());
        end
    end

    task automatic rand_pay();
        for (int i = 0; i < N_CH; i++) begin
            pay_wr[i]   = 1'($urandom);
            pay_addr[i] = ADDR_W'($urandom);
            pay_data[i] = {$urandom, $urandom};
        end
    endtask

    task automatic drive(input logic [N_CH-1:0] mask);
        logic [N_CH-1:0] pend;
        int t;
        pend = mask;
        t = 0;
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) begin
            bus.ch_req_wr[i] = pay_wr[i];
            bus.ch_req_addr[i*ADDR_W +: ADDR_W] = pay_addr[i];
            bus.ch_req_data[i*DATA_W +: DATA_W] = pay_data[i];
        end
        while (pend != '0 && t < 300) begin
            bus.ch_req_valid = pend;
            for (int i = 0; i < N_CH; i++) begin
                if (pend[i] && bus.ch_req_ready[i]) begin
                    sbq[i].push_back({pay_wr[i], pay_addr[i], {DATA_W{pay_wr[i]}} & pay_data[i]});
                    pend[i] = 1'b0;
                    acc_cyc = cyc;
                end
            end
            @(negedge clk);
            t++;
        end
        bus.ch_req_valid = '0;
        if (pend != '0) chk("accept_timeout", pend, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.ch_req_valid = '0;
        bus.msh_crd_rtn = 1'b0;
        #1;
        chk("rst_valid", bus.msh_req_valid, 0);
        chk("rst_payload", {bus.msh_req_ch, bus.msh_req_wr, bus.msh_req_addr, bus.msh_req_data}, 0);
        chk("rst_crd", bus.crd_cnt, CREDITS);
        chk("rst_ready", bus.ch_req_ready, 4'hF);
        chk("rst_err", bus.crd_err, 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < N_CH; i++) sbq[i].delete();
        ord_q.delete();
        rst_n = 1'b1;
    endtask

    function automatic int sb_left();
        int s = 0;
        for (int i = 0; i < N_CH; i++) s += sbq[i].size();
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a0, r, tot;
        logic seen;
        bus.ch_req_valid = '0;
        bus.ch_req_wr = '0;
        bus.ch_req_addr = '0;
        bus.ch_req_data = '0;
        bus.msh_crd_rtn = 1'b0;
        do_reset();

        n0 = n_iss;
        repeat (20) @(negedge clk);
        chk("idle_issues", n_iss - n0, 0);
        chk("idle_crd", bus.crd_cnt, CREDITS);
        chk("idle_ready", bus.ch_req_ready, 4'hF);

        pay_wr[2] = 1'b1;
        pay_addr[2] = 20'h00ABC;
        pay_data[2] = 64'h1122334455667788;
        drive(4'b0100);
        a0 = acc_cyc;
        n0 = n_iss;
        repeat (6) @(negedge clk);
        chk("single_issues", n_iss - n0, 1);
        chk("single_latency", last_iss - a0, 2);
        chk("single_crd", bus.crd_cnt, CREDITS - 1);

        do_reset();
        ord_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        n0 = n_iss;
        repeat (4) begin
            rand_pay();
            drive(4'hF);
        end
        repeat (12) @(negedge clk);
        chk("burst_issues", n_iss - n0, 8);
        chk("burst_crd", bus.crd_cnt, 0);
        chk("burst_quiet", bus.msh_req_valid, 0);
        bus.msh_crd_rtn = 1'b1;
        @(negedge clk);
        bus.msh_crd_rtn = 1'b0;
        repeat (5) @(negedge clk);
        chk("rtn_issues", n_iss - n0, 9);
        chk("order_left", ord_q.size(), 0);
        chk("rtn_crd", bus.crd_cnt, 0);

        rand_pay();
        drive(4'b0010);
        rand_pay();
        drive(4'b0010);
        chk("full_ready", bus.ch_req_ready[1], 0);
        rand_pay();
        fork
            begin
                drive(4'b0010);
                held_done = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        chk("held_pending", held_done, 0);
        r = cyc;
        bus.msh_crd_rtn = 1'b1;
        @(negedge clk);
        bus.msh_crd_rtn = 1'b0;
        for (int k = 0; k < 20 && !held_done; k++) @(negedge clk);
        chk("held_accepted", held_done, 1);
        chk("held_accept_cycle", acc_cyc - r, 2);
        tot = sb_left();
        for (int k = 0; k < tot; k++) begin
            bus.msh_crd_rtn = 1'b1;
            @(negedge clk);
        end
        bus.msh_crd_rtn = 1'b0;
        repeat (15) @(negedge clk);
        chk("drain_left", sb_left(), 0);
        chk("drain_crd", bus.crd_cnt, 0);
        chk("drain_err", bus.crd_err, 0);

        do_reset();
        rand_pay();
        drive(4'hF);
        a0 = acc_cyc;
        n0 = n_iss;
        bus.msh_crd_rtn = 1'b1;
        fork
            begin
                repeat (3) begin
                    rand_pay();
                    drive(4'hF);
                end
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    chk("stream_crd", bus.crd_cnt, CREDITS);
                    @(negedge clk);
                end
                bus.msh_crd_rtn = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("stream_issues", n_iss - n0, 16);
        chk("stream_span", last_iss - a0, 17);
        chk("stream_crd_end", bus.crd_cnt, CREDITS);
        chk("stream_err", bus.crd_err, 0);
        chk("stream_left", sb_left(), 0);

        rand_pay();
        drive(4'hF);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.msh_req_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midburst_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.msh_req_valid, 0);
        chk("midrst_crd", bus.crd_cnt, CREDITS);
        do_reset();

        @(negedge clk);
        chk("err_clear_start", bus.crd_err, 0);
        bus.msh_crd_rtn = 1'b1;
        @(negedge clk);
        bus.msh_crd_rtn = 1'b0;
        chk("sat_crd", bus.crd_cnt, CREDITS);
        chk("sat_err", bus.crd_err, 1);
        repeat (10) @(negedge clk);
        chk("err_sticky", bus.crd_err, 1);
        rst_n = 1'b0;
        #1;
        chk("err_reset", bus.crd_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
